coin_acceptor: RTL

- Front-end for the vending controller: converts raw, bouncy coin-mechanism sensor signals into the 2-bit `coin` code that the controller samples every clock.
- Emits exactly one single-cycle coin code per physical insertion. Invalid coins, and coins arriving while disabled, produce a `reject` pulse instead.
- Keeps saturating per-denomination tallies for audit.
- Sits between the coin slot sensor pins and the vending FSM's `coin` input.

---
 rtl/coin_acceptor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// Coin slot front-end: debounces the sensor and emits one coin code or reject
// per insertion, with saturating per-denomination tallies.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             sense,
  input  logic [1:0]       sense_type,
  input  logic             enable,
  output logic [1:0]       coin,
  output logic             reject,
  output logic             busy,
  output logic [CNT_W-1:0] n_circle,
  output logic [CNT_W-1:0] n_triangle,
  output logic [CNT_W-1:0] n_pentagon
);

  localparam int QW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    WAIT_REL,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       typ_q, typ_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [1:0]       coin_q, coin_d;
  logic             rej_q, rej_d;
  logic [CNT_W-1:0] nc_q, nc_d;
  logic [CNT_W-1:0] nt_q, nt_d;
  logic [CNT_W-1:0] np_q, np_d;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    typ_d   = typ_q;
    qcnt_d  = qcnt_q;
    gcnt_d  = gcnt_q;
    coin_d  = 2'b00;
    rej_d   = 1'b0;
    nc_d    = nc_q;
    nt_d    = nt_q;
    np_d    = np_q;
    unique case (state_q)
      IDLE: begin
        if (sense) begin
          state_d = QUAL;
          typ_d   = sense_type;
          qcnt_d  = QW'(1);
        end
      end
      QUAL: begin
        if (!sense) begin
          state_d = IDLE;
          qcnt_d  = '0;
        end else if (sense_type != typ_q) begin
          typ_d  = sense_type;
          qcnt_d = QW'(1);
        end else if (qcnt_q == QW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = WAIT_REL;
          qcnt_d  = '0;
          if (enable && typ_q != 2'b00) begin
            coin_d = typ_q;
            case (typ_q)
              2'b01:   nc_d = sat_inc(nc_q);
              2'b10:   nt_d = sat_inc(nt_q);
              default: np_d = sat_inc(np_q);
            endcase
          end else begin
            rej_d = 1'b1;
          end
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!sense) begin
          if (GAP_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gcnt_d  = GW'(1);
          end
        end
      end
      GAP: begin
        if (sense) begin
          state_d = WAIT_REL;
          gcnt_d  = '0;
        end else if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      typ_q   <= 2'b00;
      qcnt_q  <= '0;
      gcnt_q  <= '0;
      coin_q  <= 2'b00;
      rej_q   <= 1'b0;
      nc_q    <= '0;
      nt_q    <= '0;
      np_q    <= '0;
    end else begin
      state_q <= state_d;
      typ_q   <= typ_d;
      qcnt_q  <= qcnt_d;
      gcnt_q  <= gcnt_d;
      coin_q  <= coin_d;
      rej_q   <= rej_d;
      nc_q    <= nc_d;
      nt_q    <= nt_d;
      np_q    <= np_d;
    end
  end

  assign coin       = coin_q;
  assign reject     = rej_q;
  assign busy       = (state_q != IDLE);
  assign n_circle   = nc_q;
  assign n_triangle = nt_q;
  assign n_pentagon = np_q;

endmodule
